// File: rtl/cam_stream_capture.sv
// OV7670 byte-stream capture: packs byte pairs into RGB565 words and emits a
// frame-start token followed by exactly IMAGE_WIDTH*IMAGE_HEIGHT pixel words.
module cam_stream_capture #(
  parameter int          IMAGE_WIDTH  = 640,
  parameter int          IMAGE_HEIGHT = 480,
  parameter logic [15:0] PAD_PIXEL    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        queue_full,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        frame_done,
  output logic        overflow,
  output logic        size_error
);
  localparam int CW = $clog2(IMAGE_WIDTH + 1);
  localparam int RW = $clog2(IMAGE_HEIGHT + 1);
  localparam int FW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1);
  localparam logic [CW-1:0] W_MAX = CW'(IMAGE_WIDTH);
  localparam logic [RW-1:0] H_MAX = RW'(IMAGE_HEIGHT);
  localparam logic [16:0]   TOKEN = 17'h10000;
  localparam logic [16:0]   PAD_WORD = {1'b0, PAD_PIXEL};

  typedef enum logic [2:0] {
    WAIT_SYNC, START, WAIT_LINE, CAPTURE, LINE_PAD, FRAME_PAD, DROP
  } state_t;

  state_t        state_reg;
  logic          vs_reg, vs_prev_reg, hr_reg, hr_prev_reg;
  logic [7:0]    d_reg;
  logic [7:0]    pixel_hi_reg;
  logic          byte_phase_reg;
  logic          long_line_reg;
  logic          extra_seen_reg;
  logic [CW-1:0] col_cnt_reg;
  logic [RW-1:0] row_cnt_reg;
  logic [FW-1:0] fp_cnt_reg;
  logic          wr_en_reg, frame_done_reg, overflow_reg, size_error_reg;
  logic [16:0]   data_reg;
  logic          vs_fall, vs_rise, hr_rise;

  assign vs_fall = ~vs_reg & vs_prev_reg;
  assign vs_rise = vs_reg & ~vs_prev_reg;
  assign hr_rise = hr_reg & ~hr_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_reg      <= 1'b0;
      vs_prev_reg <= 1'b0;
      hr_reg      <= 1'b0;
      hr_prev_reg <= 1'b0;
      d_reg       <= 8'h00;
    end else begin
      vs_reg      <= cam_vsync;
      vs_prev_reg <= vs_reg;
      hr_reg      <= cam_href;
      hr_prev_reg <= hr_reg;
      d_reg       <= cam_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= WAIT_SYNC;
      pixel_hi_reg   <= 8'h00;
      byte_phase_reg <= 1'b0;
      long_line_reg  <= 1'b0;
      extra_seen_reg <= 1'b0;
      col_cnt_reg    <= '0;
      row_cnt_reg    <= '0;
      fp_cnt_reg     <= '0;
      wr_en_reg      <= 1'b0;
      data_reg       <= 17'h0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      size_error_reg <= 1'b0;
    end else begin
      wr_en_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      size_error_reg <= 1'b0;
      case (state_reg)
        WAIT_SYNC: if (vs_fall) state_reg <= START;

        START: begin
          if (queue_full) begin
            overflow_reg <= 1'b1;
            state_reg    <= DROP;
          end else begin
            wr_en_reg      <= 1'b1;
            data_reg       <= TOKEN;
            row_cnt_reg    <= '0;
            extra_seen_reg <= 1'b0;
            state_reg      <= WAIT_LINE;
          end
        end

        // vs is tested as a level so a rise seen while a line was still
        // being closed or padded is not lost.
        WAIT_LINE: begin
          if (vs_reg) begin
            if (row_cnt_reg < H_MAX) begin
              size_error_reg <= 1'b1;
              fp_cnt_reg     <= FW'(IMAGE_WIDTH) * FW'(H_MAX - row_cnt_reg);
              state_reg      <= FRAME_PAD;
            end else begin
              frame_done_reg <= 1'b1;
              state_reg      <= WAIT_SYNC;
            end
          end else if (hr_rise) begin
            col_cnt_reg    <= '0;
            long_line_reg  <= 1'b0;
            pixel_hi_reg   <= d_reg;
            byte_phase_reg <= 1'b1;
            state_reg      <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (!hr_reg || vs_reg) begin
            if (row_cnt_reg >= H_MAX) begin
              if (!extra_seen_reg) size_error_reg <= 1'b1;
              extra_seen_reg <= 1'b1;
              state_reg      <= WAIT_LINE;
            end else if (col_cnt_reg < W_MAX) begin
              size_error_reg <= 1'b1;
              state_reg      <= LINE_PAD;
            end else begin
              size_error_reg <= long_line_reg;
              row_cnt_reg    <= row_cnt_reg + 1'b1;
              state_reg      <= WAIT_LINE;
            end
          end else if (!byte_phase_reg) begin
            pixel_hi_reg   <= d_reg;
            byte_phase_reg <= 1'b1;
          end else begin
            byte_phase_reg <= 1'b0;
            if (row_cnt_reg < H_MAX) begin
              if (col_cnt_reg < W_MAX) begin
                if (queue_full) begin
                  overflow_reg <= 1'b1;
                  state_reg    <= DROP;
                end else begin
                  wr_en_reg   <= 1'b1;
                  data_reg    <= {1'b0, pixel_hi_reg, d_reg};
                  col_cnt_reg <= col_cnt_reg + 1'b1;
                end
              end else begin
                long_line_reg <= 1'b1;
              end
            end
          end
        end

        LINE_PAD: begin
          if (col_cnt_reg == W_MAX) begin
            row_cnt_reg <= row_cnt_reg + 1'b1;
            state_reg   <= WAIT_LINE;
          end else if (queue_full) begin
            overflow_reg <= 1'b1;
            state_reg    <= DROP;
          end else begin
            wr_en_reg   <= 1'b1;
            data_reg    <= PAD_WORD;
            col_cnt_reg <= col_cnt_reg + 1'b1;
          end
        end

        FRAME_PAD: begin
          if (fp_cnt_reg == '0) begin
            frame_done_reg <= 1'b1;
            state_reg      <= WAIT_SYNC;
          end else if (queue_full) begin
            overflow_reg <= 1'b1;
            state_reg    <= DROP;
          end else begin
            wr_en_reg  <= 1'b1;
            data_reg   <= PAD_WORD;
            fp_cnt_reg <= fp_cnt_reg - 1'b1;
          end
        end

        DROP: if (vs_rise) state_reg <= WAIT_SYNC;

        default: state_reg <= WAIT_SYNC;
      endcase
    end
  end

  assign queue_wr_en = wr_en_reg;
  assign queue_data  = data_reg;
  assign frame_done  = frame_done_reg;
  assign overflow    = overflow_reg;
  assign size_error  = size_error_reg;
endmodule
